y_row_fetch_ctrl: RTL and testbench
===================================

Name: y_row_fetch_ctrl

Overview:
Parametrised Y-matrix row fetch controller. It accepts a row number over a valid/ready handshake and reads the pointer line holding that row's start address from Y line memory. It extracts the row's start-line pointer and streams LINES_PER_ROW consecutive line addresses, one per handshake, to the Y datapath. It also supports a "continue" mode that streams the next lines without a pointer lookup, and flags rows whose pointer is null.

Parameters:
ROW_W, 16, width of row number
ADDR_W, 11, line-memory address width
LINE_W, 256, line-memory data width
PTRS_PER_LINE, 16, pointers packed per line (power of 2); field width PF_W = LINE_W/PTRS_PER_LINE, with PF_W >= ADDR_W
LINES_PER_ROW, 2, consecutive lines issued per request (>=1)
RD_LAT, 1, memory read latency in cycles (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_row  in  ROW_W  row number; all-ones = continue request
mem_rd_en  out  1  pointer-line read strobe, one-cycle pulse
mem_rd_addr  out  ADDR_W  pointer-line address
mem_rd_data  in  LINE_W  read data, valid RD_LAT cycles after mem_rd_en
line_valid  out  1  line address valid
line_ready  in  1  consumer accepts line address
line_addr  out  ADDR_W  line address to fetch
line_first  out  1  first line of the current request
line_last  out  1  last line of the current request
null_row  out  1  one-cycle pulse: pointer was null, no lines issued
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, high): state=IDLE; mem_rd_en=0, mem_rd_addr=0, line_valid=0, line_addr=0, line_first=0, line_last=0, null_row=0; internal next-line register nxt=0; line counter=0. Reset wins over every other event, including mid-burst and an outstanding memory read (any later read data is ignored).
- req_ready = (state==IDLE) & ~reset (combinational). A request is accepted when req_valid & req_ready.
- States: IDLE, PTR_RD, PTR_WAIT, ISSUE.
- IDLE, normal row accepted in cycle T: latch row, go to PTR_RD.
- PTR_RD (cycle T+1): mem_rd_en=1; mem_rd_addr = (row / PTRS_PER_LINE) truncated to ADDR_W. Go to PTR_WAIT and load the wait counter with RD_LAT.
- PTR_WAIT: decrement the counter. In the cycle where mem_rd_data is valid (T+1+RD_LAT), select field k = row mod PTRS_PER_LINE, i.e. bits [k*PF_W +: PF_W], and take ptr = its low ADDR_W bits.
  - ptr all-ones: null_row=1 for that next cycle; return to IDLE; nxt unchanged.
  - Otherwise: base=ptr and go to ISSUE. First line_valid appears at T+2+RD_LAT (T+3 at default).
- IDLE, continue request (req_row all-ones) accepted in cycle T: base=nxt; go directly to ISSUE. First line_valid appears at T+1. No memory read is issued.
- ISSUE: line_addr = base + i (mod 2^ADDR_W, wraps), for i = 0..LINES_PER_ROW-1.
  - line_first=(i==0); line_last=(i==LINES_PER_ROW-1); with LINES_PER_ROW=1 both are 1.
  - i advances only on line_valid & line_ready. While line_ready=0, line_addr, line_first and line_last stay stable and line_valid stays 1.
  - On the handshake of the last line: nxt = line_addr+1 (mod), line_valid drops next cycle, state returns to IDLE.
  - A back-to-back new request is accepted no earlier than the cycle after returning to IDLE (no overlap).
- mem_rd_en is never asserted outside PTR_RD. null_row and line_valid are never asserted in the same cycle.
- Arithmetic is unsigned. The row-to-address division is a shift by log2(PTRS_PER_LINE). High row bits beyond ADDR_W after the shift are discarded.

Test Plan:
- Defaults, reset released, req_row=0x0025 with memory line 0x002 holding field 5 (bits[95:80]) = 0x0123 -> mem_rd_en at T+1 with addr 0x002. line_addr 0x123 (first) at T+3, then 0x124 (last). busy drops after the last handshake.
- Continue request 0xFFFF after the previous test -> no mem_rd_en; line_addr 0x125 at T+1, then 0x126. Then a row whose pointer is 0x7FE followed by continue -> 0x7FE, 0x7FF, then 0x000, 0x001 (wrap).
- Field value 0xF7FF (low 11 bits all ones) -> single-cycle null_row, no line_valid. nxt is unchanged, so a following continue resumes from the prior nxt.
- Hold line_ready=0 for 5 cycles on the first line -> line_valid=1 and line_addr=0x123 stable throughout, req_ready=0. Release -> sequence completes normally.
- Assert reset in PTR_WAIT, and separately mid-ISSUE -> next cycle all outputs 0, state IDLE. A stale mem_rd_data arriving later produces no output. A continue request after reset starts at 0x000.
- LINES_PER_ROW=4, RD_LAT=3, PTRS_PER_LINE=8 build: row 0x0013 -> read addr 0x002, field 3 (32-bit field). First line at T+5, four lines issued, line_first only on the first and line_last only on the fourth.

Source files
------------

// File: rtl/y_row_fetch_ctrl.sv
// Y-matrix row fetch controller: looks up a row's start-line pointer in Y line
// memory and streams LINES_PER_ROW consecutive line addresses to the datapath.
module y_row_fetch_ctrl #(
    parameter int ROW_W         = 16,
    parameter int ADDR_W        = 11,
    parameter int LINE_W        = 256,
    parameter int PTRS_PER_LINE = 16,
    parameter int LINES_PER_ROW = 2,
    parameter int RD_LAT        = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ROW_W-1:0]  req_row,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [LINE_W-1:0] mem_rd_data,
    output logic              line_valid,
    input  logic              line_ready,
    output logic [ADDR_W-1:0] line_addr,
    output logic              line_first,
    output logic              line_last,
    output logic              null_row,
    output logic              busy
);

    localparam int PF_W  = LINE_W / PTRS_PER_LINE;
    localparam int SEL_W = (PTRS_PER_LINE > 1) ? $clog2(PTRS_PER_LINE) : 1;
    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam int IDX_W = (LINES_PER_ROW > 1) ? $clog2(LINES_PER_ROW) : 1;

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(RD_LAT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINES_PER_ROW - 1);
    localparam logic             ONE_LINE  = (LINES_PER_ROW == 1);

    typedef enum logic [1:0] {
        IDLE,
        PTR_RD,
        PTR_WAIT,
        ISSUE
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [CNT_W-1:0]   waitCnt;
    logic [CNT_W-1:0]   waitCntNext;
    logic [IDX_W-1:0]   lineIdx;
    logic [IDX_W-1:0]   lineIdxNext;
    logic [ADDR_W-1:0]  nxt;
    logic [ADDR_W-1:0]  nxtNext;
    logic [SEL_W-1:0]   fieldIdx;
    logic [SEL_W-1:0]   fieldIdxNext;
    logic               memRdEnNext;
    logic [ADDR_W-1:0]  memRdAddrNext;
    logic               lineValidNext;
    logic [ADDR_W-1:0]  lineAddrNext;
    logic               lineFirstNext;
    logic               lineLastNext;
    logic               nullRowNext;
    logic [ADDR_W-1:0]  rdPtr;

    // Only the low ADDR_W bits of the selected pointer field are meaningful.
    assign rdPtr     = mem_rd_data[fieldIdx * PF_W +: ADDR_W];
    assign req_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);

    always_comb begin
        stateNext     = state;
        waitCntNext   = waitCnt;
        lineIdxNext   = lineIdx;
        nxtNext       = nxt;
        fieldIdxNext  = fieldIdx;
        memRdEnNext   = 1'b0;
        memRdAddrNext = mem_rd_addr;
        lineValidNext = line_valid;
        lineAddrNext  = line_addr;
        lineFirstNext = line_first;
        lineLastNext  = line_last;
        nullRowNext   = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_row == '1) begin
                        // Continue request: resume right after the last issued line.
                        stateNext     = ISSUE;
                        lineIdxNext   = '0;
                        lineValidNext = 1'b1;
                        lineAddrNext  = nxt;
                        lineFirstNext = 1'b1;
                        lineLastNext  = ONE_LINE;
                    end else begin
                        stateNext     = PTR_RD;
                        memRdEnNext   = 1'b1;
                        memRdAddrNext = ADDR_W'(req_row >> SEL_W);
                        fieldIdxNext  = req_row[SEL_W-1:0];
                    end
                end
            end

            PTR_RD: begin
                stateNext   = PTR_WAIT;
                waitCntNext = WAIT_INIT;
            end

            PTR_WAIT: begin
                waitCntNext = waitCnt - 1'b1;
                if (waitCnt == CNT_W'(1)) begin
                    if (rdPtr == '1) begin
                        nullRowNext = 1'b1;
                        stateNext   = IDLE;
                    end else begin
                        stateNext     = ISSUE;
                        lineIdxNext   = '0;
                        lineValidNext = 1'b1;
                        lineAddrNext  = rdPtr;
                        lineFirstNext = 1'b1;
                        lineLastNext  = ONE_LINE;
                    end
                end
            end

            ISSUE: begin
                if (line_ready) begin
                    if (lineIdx == LAST_IDX) begin
                        nxtNext       = line_addr + 1'b1;
                        lineValidNext = 1'b0;
                        lineFirstNext = 1'b0;
                        lineLastNext  = 1'b0;
                        stateNext     = IDLE;
                    end else begin
                        lineIdxNext   = lineIdx + 1'b1;
                        lineAddrNext  = line_addr + 1'b1;
                        lineFirstNext = 1'b0;
                        lineLastNext  = (lineIdxNext == LAST_IDX);
                    end
                end
            end

            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            waitCnt     <= '0;
            lineIdx     <= '0;
            nxt         <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            line_valid  <= 1'b0;
            line_addr   <= '0;
            line_first  <= 1'b0;
            line_last   <= 1'b0;
            null_row    <= 1'b0;
        end else begin
            state       <= stateNext;
            waitCnt     <= waitCntNext;
            lineIdx     <= lineIdxNext;
            nxt         <= nxtNext;
            mem_rd_en   <= memRdEnNext;
            mem_rd_addr <= memRdAddrNext;
            line_valid  <= lineValidNext;
            line_addr   <= lineAddrNext;
            line_first  <= lineFirstNext;
            line_last   <= lineLastNext;
            null_row    <= nullRowNext;
        end
    end

    // Field selector is pure data; it is always rewritten before it is used.
    always_ff @(posedge clock) begin
        fieldIdx <= fieldIdxNext;
    end

endmodule

// File: tb/tb_y_row_fetch_ctrl.sv
// Bench for y_row_fetch_ctrl: default build driven from a cycle table plus
// reset corner sequences, and a LINES_PER_ROW=4 / RD_LAT=3 / PTRS_PER_LINE=8 build.
module tb_y_row_fetch_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    // Default build (A)
    logic         reqValidA, reqReadyA, memRdEnA, lineValidA, lineReadyA;
    logic         lineFirstA, lineLastA, nullRowA, busyA;
    logic [15:0]  reqRowA;
    logic [10:0]  memRdAddrA, lineAddrA;
    logic [255:0] memRdDataA = '1;

    // Wide build (B)
    logic         reqValidB, reqReadyB, memRdEnB, lineValidB, lineReadyB;
    logic         lineFirstB, lineLastB, nullRowB, busyB;
    logic [15:0]  reqRowB;
    logic [10:0]  memRdAddrB, lineAddrB;
    logic [255:0] memRdDataB;
    logic [255:0] pB1 = '1, pB2 = '1, pB3 = '1;

    y_row_fetch_ctrl dutA (
        .clock(clock), .reset(reset),
        .req_valid(reqValidA), .req_ready(reqReadyA), .req_row(reqRowA),
        .mem_rd_en(memRdEnA), .mem_rd_addr(memRdAddrA), .mem_rd_data(memRdDataA),
        .line_valid(lineValidA), .line_ready(lineReadyA), .line_addr(lineAddrA),
        .line_first(lineFirstA), .line_last(lineLastA), .null_row(nullRowA), .busy(busyA)
    );

    y_row_fetch_ctrl #(.LINES_PER_ROW(4), .RD_LAT(3), .PTRS_PER_LINE(8)) dutB (
        .clock(clock), .reset(reset),
        .req_valid(reqValidB), .req_ready(reqReadyB), .req_row(reqRowB),
        .mem_rd_en(memRdEnB), .mem_rd_addr(memRdAddrB), .mem_rd_data(memRdDataB),
        .line_valid(lineValidB), .line_ready(lineReadyB), .line_addr(lineAddrB),
        .line_first(lineFirstB), .line_last(lineLastB), .null_row(nullRowB), .busy(busyB)
    );

    // Line memories; unread cycles return all-ones so a mistimed sample looks null.
    logic [255:0] memA [int];
    logic [255:0] memB [int];

    function automatic logic [255:0] lookA(input logic [10:0] a);
        if (memA.exists(int'(a))) return memA[int'(a)];
        return '0;
    endfunction

    function automatic logic [255:0] lookB(input logic [10:0] a);
        if (memB.exists(int'(a))) return memB[int'(a)];
        return '0;
    endfunction

    always @(posedge clock) memRdDataA <= memRdEnA ? lookA(memRdAddrA) : '1;

    always @(posedge clock) begin
        pB1 <= memRdEnB ? lookB(memRdAddrB) : '1;
        pB2 <= pB1;
        pB3 <= pB2;
    end
    assign memRdDataB = pB3;

    typedef struct packed {
        logic        rdy;
        logic        en;
        logic [10:0] addr;
        logic        lv;
        logic [10:0] la;
        logic        f;
        logic        l;
        logic        nul;
        logic        busy;
    } outs_t;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] row;
        logic        lrdy;
        outs_t       exp;
    } vec_t;

    vec_t vecs[$];
    int   nCmp  = 0;
    int   nFail = 0;

    function automatic outs_t o(input logic rdy, input logic en, input logic [10:0] addr,
                                input logic lv, input logic [10:0] la, input logic f,
                                input logic l, input logic nul, input logic bz);
        outs_t r;
        r = {rdy, en, addr, lv, la, f, l, nul, bz};
        return r;
    endfunction

    function automatic vec_t v(input logic rst, input logic vld, input logic [15:0] row,
                               input logic lrdy, input outs_t e);
        vec_t r;
        r.rst = rst; r.vld = vld; r.row = row; r.lrdy = lrdy; r.exp = e;
        return r;
    endfunction

    function automatic string fmt(input outs_t x);
        return $sformatf("rdy=%0b en=%0b addr=%h lv=%0b la=%h first=%0b last=%0b null=%0b busy=%0b",
                         x.rdy, x.en, x.addr, x.lv, x.la, x.f, x.l, x.nul, x.busy);
    endfunction

    task automatic drvA(input logic rst, input logic vld, input logic [15:0] row, input logic lrdy);
        @(negedge clock);
        reset = rst; reqValidA = vld; reqRowA = row; lineReadyA = lrdy;
        #1;
    endtask

    task automatic checkA(input string nm, input outs_t e);
        outs_t act;
        act = {reqReadyA, memRdEnA, memRdAddrA, lineValidA, lineAddrA,
               lineFirstA, lineLastA, nullRowA, busyA};
        nCmp++;
        if (act !== e) begin
            nFail++;
            $display("FAIL %s: got %s, want %s", nm, fmt(act), fmt(e));
        end
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] e);
        nCmp++;
        if (act !== e) begin
            nFail++;
            $display("FAIL %s: got %h, want %h", nm, act, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [255:0] tmp;
        int k;

        reset = 1'b1;
        reqValidA = 0; reqRowA = '0; lineReadyA = 0;
        reqValidB = 0; reqRowB = '0; lineReadyB = 0;

        tmp = '1; tmp[95:80]  = 16'h0123; memA[2] = tmp;
        tmp = '1; tmp[31:16]  = 16'h07FE; memA[3] = tmp;
        tmp = '0; tmp[47:32]  = 16'hF7FF; memA[4] = tmp;
        tmp = '1; tmp[127:96] = 32'h0000_0040; memB[2] = tmp;

        // rst vld row lrdy | rdy en addr lv la f l null busy
        vecs.push_back(v(1, 0, 16'h0000, 0, o(0, 0, 11'h000, 0, 11'h000, 0, 0, 0, 0)));
        vecs.push_back(v(0, 0, 16'h0000, 0, o(1, 0, 11'h000, 0, 11'h000, 0, 0, 0, 0)));
        vecs.push_back(v(0, 1, 16'h0025, 1, o(1, 0, 11'h000, 0, 11'h000, 0, 0, 0, 0)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 1, 11'h002, 0, 11'h000, 0, 0, 0, 1)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 0, 11'h002, 0, 11'h000, 0, 0, 0, 1)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 0, 11'h002, 1, 11'h123, 1, 0, 0, 1)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 0, 11'h002, 1, 11'h124, 0, 1, 0, 1)));
        vecs.push_back(v(0, 1, 16'hFFFF, 1, o(1, 0, 11'h002, 0, 11'h124, 0, 0, 0, 0)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 0, 11'h002, 1, 11'h125, 1, 0, 0, 1)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 0, 11'h002, 1, 11'h126, 0, 1, 0, 1)));
        vecs.push_back(v(0, 1, 16'h0031, 1, o(1, 0, 11'h002, 0, 11'h126, 0, 0, 0, 0)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 1, 11'h003, 0, 11'h126, 0, 0, 0, 1)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 0, 11'h003, 0, 11'h126, 0, 0, 0, 1)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 0, 11'h003, 1, 11'h7FE, 1, 0, 0, 1)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 0, 11'h003, 1, 11'h7FF, 0, 1, 0, 1)));
        vecs.push_back(v(0, 1, 16'hFFFF, 1, o(1, 0, 11'h003, 0, 11'h7FF, 0, 0, 0, 0)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 0, 11'h003, 1, 11'h000, 1, 0, 0, 1)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 0, 11'h003, 1, 11'h001, 0, 1, 0, 1)));
        vecs.push_back(v(0, 1, 16'h0042, 1, o(1, 0, 11'h003, 0, 11'h001, 0, 0, 0, 0)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 1, 11'h004, 0, 11'h001, 0, 0, 0, 1)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 0, 11'h004, 0, 11'h001, 0, 0, 0, 1)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(1, 0, 11'h004, 0, 11'h001, 0, 0, 1, 0)));
        vecs.push_back(v(0, 1, 16'hFFFF, 1, o(1, 0, 11'h004, 0, 11'h001, 0, 0, 0, 0)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 0, 11'h004, 1, 11'h002, 1, 0, 0, 1)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 0, 11'h004, 1, 11'h003, 0, 1, 0, 1)));
        vecs.push_back(v(0, 1, 16'h0025, 1, o(1, 0, 11'h004, 0, 11'h003, 0, 0, 0, 0)));
        vecs.push_back(v(0, 0, 16'h0000, 0, o(0, 1, 11'h002, 0, 11'h003, 0, 0, 0, 1)));
        vecs.push_back(v(0, 0, 16'h0000, 0, o(0, 0, 11'h002, 0, 11'h003, 0, 0, 0, 1)));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(0, 0, 16'h0000, 0, o(0, 0, 11'h002, 1, 11'h123, 1, 0, 0, 1)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 0, 11'h002, 1, 11'h123, 1, 0, 0, 1)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(0, 0, 11'h002, 1, 11'h124, 0, 1, 0, 1)));
        vecs.push_back(v(0, 0, 16'h0000, 1, o(1, 0, 11'h002, 0, 11'h124, 0, 0, 0, 0)));

        repeat (2) @(posedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            drvA(vecs[i].rst, vecs[i].vld, vecs[i].row, vecs[i].lrdy);
            checkA($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset while waiting on the pointer read.
        drvA(0, 1, 16'h0025, 1); checkA("r1_accept", o(1, 0, 11'h002, 0, 11'h124, 0, 0, 0, 0));
        drvA(0, 0, 16'h0000, 1); checkA("r1_ptr_rd", o(0, 1, 11'h002, 0, 11'h124, 0, 0, 0, 1));
        drvA(1, 0, 16'h0000, 1); checkA("r1_wait_in_reset", o(0, 0, 11'h002, 0, 11'h124, 0, 0, 0, 1));
        drvA(0, 0, 16'h0000, 1); checkA("r1_after_reset", o(1, 0, 11'h000, 0, 11'h000, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            drvA(0, 0, 16'h0000, 1);
            checkA($sformatf("r1_quiet%0d", i), o(1, 0, 11'h000, 0, 11'h000, 0, 0, 0, 0));
        end

        // Continue after reset starts at line 0; then reset mid-burst.
        drvA(0, 1, 16'hFFFF, 0); checkA("r2_accept", o(1, 0, 11'h000, 0, 11'h000, 0, 0, 0, 0));
        drvA(0, 0, 16'h0000, 0); checkA("r2_first", o(0, 0, 11'h000, 1, 11'h000, 1, 0, 0, 1));
        drvA(1, 0, 16'h0000, 0); checkA("r2_issue_in_reset", o(0, 0, 11'h000, 1, 11'h000, 1, 0, 0, 1));
        drvA(0, 0, 16'h0000, 1); checkA("r2_after_reset", o(1, 0, 11'h000, 0, 11'h000, 0, 0, 0, 0));
        drvA(0, 1, 16'hFFFF, 1); checkA("r2_cont_accept", o(1, 0, 11'h000, 0, 11'h000, 0, 0, 0, 0));
        drvA(0, 0, 16'h0000, 1); checkA("r2_cont_l0", o(0, 0, 11'h000, 1, 11'h000, 1, 0, 0, 1));
        drvA(0, 0, 16'h0000, 1); checkA("r2_cont_l1", o(0, 0, 11'h000, 1, 11'h001, 0, 1, 0, 1));
        drvA(0, 0, 16'h0000, 1); checkA("r2_cont_done", o(1, 0, 11'h000, 0, 11'h001, 0, 0, 0, 0));

        // Wide build: row 0x13 -> line 2, field 3 holds 0x040.
        @(negedge clock);
        reqValidB = 1; reqRowB = 16'h0013; lineReadyB = 1;
        #1;
        cmp("b_req_ready", 32'(reqReadyB), 32'd1);
        @(negedge clock);
        reqValidB = 0;
        #1;
        cmp("b_rd_en", 32'(memRdEnB), 32'd1);
        cmp("b_rd_addr", 32'(memRdAddrB), 32'h002);
        k = 1;
        while (!lineValidB && k < 12) begin
            @(negedge clock);
            #1;
            k++;
            cmp("b_no_null", 32'(nullRowB), 32'd0);
        end
        cmp("b_first_latency", 32'(k), 32'd5);
        for (int j = 0; j < 4; j++) begin
            cmp($sformatf("b_lv%0d", j), 32'(lineValidB), 32'd1);
            cmp($sformatf("b_la%0d", j), 32'(lineAddrB), 32'h040 + 32'(j));
            cmp($sformatf("b_first%0d", j), 32'(lineFirstB), 32'(j == 0));
            cmp($sformatf("b_last%0d", j), 32'(lineLastB), 32'(j == 3));
            @(negedge clock);
            #1;
        end
        cmp("b_done_lv", 32'(lineValidB), 32'd0);
        cmp("b_done_busy", 32'(busyB), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
